data_ram_pipe: RTL and testbench
================================

// Module: data_ram_pipe
// PURPOSE
//  Parametrised single-port data RAM with valid/ready request and response channels.
//  Generalises the fixed 1-cycle CPU test RAM:
//   - configurable data width, depth and read latency;
//   - byte-address decode and byte-lane strobes;
//   - credit-limited response buffering, so a stalled consumer never loses data.
//  Sits between the CPU data port (or a bus arbiter) and on-chip memory.
// PARAMETERS
//  DATA_W      32   data width in bits; multiple of 8; lanes NB = DATA_W/8
//  WORDS       256  memory depth in words; power of two
//  ADDR_W      32   byte-address width
//  LATENCY     1    read pipeline stages, accept to earliest resp_valid; 1..4
//  RESP_DEPTH  4    response FIFO depth; must be >= LATENCY
// PORTS
//  clk         in   1       clock, rising edge
//  resetn      in   1       asynchronous active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       request accepted when req_valid & req_ready
//  req_addr    in   ADDR_W  byte address; low log2(NB) bits ignored
//  req_wstrb   in   NB      byte write enables; all-zero = read
//  req_wdata   in   DATA_W  write data, lane i = bits [8i+7:8i]
//  resp_valid  out  1       response present
//  resp_ready  in   1       response consumed when resp_valid & resp_ready
//  resp_rdata  out  DATA_W  read data; 0 for writes
//  resp_err    out  1       error flag (RAM_BOUNDS_CHECK_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (resetn low, async):
//     - pipeline valids, FIFO pointers and credit counter cleared;
//     - resp_valid=0, resp_rdata=0, resp_err=0; req_ready=0 while resetn low.
//     - Memory contents not reset.
//  - Mid-operation reset: in-flight reads and buffered responses are discarded; writes already accepted persist.
//  - Index: idx = req_addr[ADDR_W-1:log2(NB)], truncated to log2(WORDS) bits, so address wraps modulo WORDS.
//  - Write:
//     - applied at the accepting edge to the lanes with req_wstrb set; other lanes unchanged;
//     - a read accepted on the next cycle returns the new data.
//  - Read: mem[idx] sampled at the accepting edge, delayed through LATENCY-1 valid-tagged stages.
//  - Every accepted request, read or write, yields exactly one response, in order.
//  - Credits:
//     - outstanding = in pipeline + in FIFO;
//     - req_ready = (outstanding < RESP_DEPTH);
//     - accept and pop in the same cycle leave the count unchanged.
//  - Bypass: if the FIFO is empty and resp_ready=1 when a stage output becomes valid, it is still written and popped through the FIFO.
//     - FIFO is show-ahead; latency is LATENCY cycles.
//  - Full: no accept while outstanding == RESP_DEPTH, even if resp_ready=1 in that cycle (registered credit; one bubble).
//  - resp_* hold stable while resp_valid & !resp_ready.
// CONFIGURATION
//  - RAM_BOUNDS_CHECK_EN defined:
//     - full index >= WORDS ==> write suppressed, resp_rdata=0, resp_err=1;
//     - the response is still ordered and still consumes a credit.
//  - RAM_BOUNDS_CHECK_EN undefined: index wraps, resp_err constant 0.
// STRUCTURE
//  - Package ram_pkg:
//     - localparams NB_OF(DATA_W) and IDX_W = $clog2(WORDS);
//     - typedef ram_resp_t {logic [DATA_W-1:0] rdata; logic err;}.
//  - Sub-module resp_fifo (show-ahead, RESP_DEPTH entries, ram_resp_t payload) holds the response buffer.
//  - Memory array and pipeline live in the top.
// TESTING
//  1 Reset, then sw 0x01020304 to addr 0, strobe 4'b1111; lb-style read addr 1 ==> resp_rdata 0x01020304, resp_valid exactly LATENCY cycles after accept.
//  2 mem[0]=0xFFFFFFFF, write strobe 4'b0100 data 0x00AA0000 ==> read returns 0xFFAAFFFF; write response has rdata 0.
//  3 Backpressure: resp_ready=0, issue 6 reads with RESP_DEPTH=4 ==> req_ready low after 4 accepts; release ==> 4 responses in issue order, then remaining 2 accepted.
//  4 Back-to-back write addr 8 data 0x55 then read addr 8 next cycle ==> read returns 0x55.
//  5 Address 4*WORDS ==> with macro: resp_err=1, rdata 0, mem[0] unchanged; without: aliases mem[0].
//  6 Assert resetn low with 3 reads outstanding ==> resp_valid=0 immediately; after release no stale responses; prior write data intact.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared sizing helpers and response type for data_ram_pipe
// Optional feature macro used by the top: RAM_BOUNDS_CHECK_EN
package ram_pkg;

   localparam int RAM_DATA_W = 32;
   localparam int RAM_WORDS  = 256;

   function automatic int NB_OF(input int data_w);
      return data_w / 8;
   endfunction

   localparam int NB    = NB_OF(RAM_DATA_W);
   localparam int IDX_W = $clog2(RAM_WORDS);

   typedef struct packed {
      logic [RAM_DATA_W-1:0] rdata;
      logic                  err;
   } ram_resp_t;

endpackage

// File: rtl/resp_fifo.sv
// rtl/resp_fifo.sv - show-ahead response buffer; head is valid whenever count is nonzero
// Overflow is prevented upstream by the credit counter, so push never meets a full FIFO.
module resp_fifo
   import ram_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = ram_resp_t
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output logic valid,
   output T     head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   T              store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_pop = pop && valid;
   assign valid  = (count != '0);
   assign head   = store[rd_ptr];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= bump(wr_ptr);
         if (do_pop) rd_ptr <= bump(rd_ptr);
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Payload storage is left unreset; consumers only look at it behind valid.
   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/data_ram_pipe.sv
// rtl/data_ram_pipe.sv - single-port data RAM with valid/ready request/response and credit-limited buffering
// Optional feature macro: RAM_BOUNDS_CHECK_EN (out-of-range index flags resp_err instead of wrapping)
module data_ram_pipe
   import ram_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int WORDS      = 256,
   parameter int ADDR_W     = 32,
   parameter int LATENCY    = 1,
   parameter int RESP_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W/8-1:0]   req_wstrb,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err
);

   localparam int LANES = NB_OF(DATA_W);
   localparam int LB    = $clog2(LANES);
   localparam int IW    = $clog2(WORDS);
   localparam int CW    = $clog2(RESP_DEPTH + 1);

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } resp_t;

   logic [DATA_W-1:0] mem [WORDS];
   logic [CW-1:0]     outstanding;
   logic              accept;
   logic              is_write;
   logic              oob;
   logic              push;
   logic              pop;
   logic              fifo_valid;
   logic [ADDR_W-1:0] word_addr;
   logic [IW-1:0]     idx;
   resp_t             head_d;
   resp_t             push_d;
   resp_t             fifo_head;
   logic              unused_bits;

   // Credit is taken from the registered count only, so a pop frees a slot one cycle later.
   assign req_ready = resetn && (outstanding < CW'(RESP_DEPTH));
   assign accept    = req_valid && req_ready;
   assign is_write  = |req_wstrb;
   assign word_addr = req_addr >> LB;
   assign idx       = word_addr[IW-1:0];

`ifdef RAM_BOUNDS_CHECK_EN
   assign oob = (word_addr >> IW) != '0;
`else
   assign oob = 1'b0;
`endif

   always_comb begin
      head_d = '0;
      if (oob) begin
         head_d.err = 1'b1;
      end else if (!is_write) begin
         head_d.rdata = mem[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (accept && is_write && !oob) begin
         for (int i = 0; i < LANES; i++) begin
            if (req_wstrb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

   // Stage 0 is the sample taken at the accepting edge; LATENCY-1 registered stages follow.
   generate
      if (LATENCY == 1) begin : g_direct
         assign push   = accept;
         assign push_d = head_d;
      end else begin : g_pipe
         logic [LATENCY-2:0] stage_v;
         resp_t              stage_d [LATENCY-1];

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               stage_v <= '0;
               for (int k = 0; k < LATENCY - 1; k++) stage_d[k] <= '0;
            end else begin
               stage_v[0] <= accept;
               stage_d[0] <= head_d;
               for (int k = 1; k < LATENCY - 1; k++) begin
                  stage_v[k] <= stage_v[k-1];
                  stage_d[k] <= stage_d[k-1];
               end
            end
         end

         assign push   = stage_v[LATENCY-2];
         assign push_d = stage_d[LATENCY-2];
      end
   endgenerate

   resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .T     (resp_t)
   ) u_resp_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push),
      .push_data (push_d),
      .pop       (pop),
      .valid     (fifo_valid),
      .head      (fifo_head)
   );

   assign pop = fifo_valid && resp_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         outstanding <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: ;
         endcase
      end
   end

   assign resp_valid = fifo_valid;
   assign resp_rdata = fifo_valid ? fifo_head.rdata : '0;

`ifdef RAM_BOUNDS_CHECK_EN
   assign resp_err = fifo_valid && fifo_head.err;
`else
   assign resp_err = 1'b0;
`endif

   assign unused_bits = ^{req_addr, word_addr, fifo_head.err, oob};

endmodule

// File: tb/tb_data_ram_pipe.sv
// tb/tb_data_ram_pipe.sv - randomized self-checking bench for data_ram_pipe against a word-array model
module tb_data_ram_pipe;

   localparam int DATA_W     = 32;
   localparam int WORDS      = 256;
   localparam int ADDR_W     = 32;
   localparam int LATENCY    = 1;
   localparam int RESP_DEPTH = 4;
   localparam int NB         = DATA_W / 8;

   logic              clk        = 1'b0;
   logic              resetn     = 1'b0;
   logic              req_valid  = 1'b0;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr   = '0;
   logic [NB-1:0]     req_wstrb  = '0;
   logic [DATA_W-1:0] req_wdata  = '0;
   logic              resp_valid;
   logic              resp_ready = 1'b0;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   int nvec = 0;
   int nerr = 0;

   logic [DATA_W-1:0] mdl [WORDS];
   logic [DATA_W:0]   exp_q [$];

   always #5 clk = ~clk;

   data_ram_pipe #(
      .DATA_W     (DATA_W),
      .WORDS      (WORDS),
      .ADDR_W     (ADDR_W),
      .LATENCY    (LATENCY),
      .RESP_DEPTH (RESP_DEPTH)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_wstrb  (req_wstrb),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   // Returns {err, rdata} of the response and applies any write to the model.
   function automatic logic [DATA_W:0] model_access(input logic [ADDR_W-1:0] addr,
                                                    input logic [NB-1:0] strb,
                                                    input logic [DATA_W-1:0] wdata);
      longint unsigned word = longint'(addr) / NB;
      int idx = int'(word % WORDS);
`ifdef RAM_BOUNDS_CHECK_EN
      if (word >= WORDS) return {1'b1, {DATA_W{1'b0}}};
`endif
      if (strb == '0) return {1'b0, mdl[idx]};
      for (int i = 0; i < NB; i++) begin
         if (strb[i]) mdl[idx][8*i +: 8] = wdata[8*i +: 8];
      end
      return '0;
   endfunction

   task automatic issue(input logic [ADDR_W-1:0] addr, input logic [NB-1:0] strb,
                        input logic [DATA_W-1:0] data);
      logic ok;
      ok = 1'b0;
      req_addr  = addr;
      req_wstrb = strb;
      req_wdata = data;
      req_valid = 1'b1;
      for (int t = 0; t < 50 && !ok; t++) begin
         if (req_ready) begin
            exp_q.push_back(model_access(addr, strb, data));
            ok = 1'b1;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      if (!ok) begin
         nvec++; nerr++;
         $display("FAIL issue_timeout addr=%h req_ready=%b required 1 within 50 cycles", addr, req_ready);
      end
   endtask

   task automatic collect(output logic [DATA_W:0] got, output logic [DATA_W:0] exp, output int lat);
      lat = 1;
      for (int t = 0; t < 50 && !resp_valid; t++) begin
         @(negedge clk);
         lat++;
      end
      got = {resp_err, resp_rdata};
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : {(DATA_W+1){1'bx}};
      if (!resp_valid) begin
         nvec++; nerr++;
         $display("FAIL collect_timeout resp_valid=0 required 1 within 50 cycles");
      end else begin
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      nvec++;
      if ({req_ready, resp_valid, resp_err, resp_rdata} !== {3'b000, {DATA_W{1'b0}}}) begin
         nerr++;
         $display("FAIL reset_outputs got ready=%b valid=%b err=%b rdata=%h required 0/0/0/0",
                  req_ready, resp_valid, resp_err, resp_rdata);
      end
      resetn = 1'b1;
      @(negedge clk);
      nvec++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         nerr++;
         $display("FAIL reset_release got ready=%b valid=%b required 1/0", req_ready, resp_valid);
      end
   endtask

   task automatic test_fill();
      logic [DATA_W:0] got, exp;
      int lat;
      for (int w = 0; w < WORDS; w++) begin
         issue(ADDR_W'(w * NB), {NB{1'b1}}, $urandom);
         collect(got, exp, lat);
         nvec++;
         if (got !== exp) begin
            nerr++;
            $display("FAIL fill_resp word=%0d got=%h required %h", w, got, exp);
         end
      end
   endtask

   task automatic test_basic();
      logic [DATA_W:0] got, exp;
      int lat;
      issue(32'd0, 4'hF, 32'h0102_0304);
      collect(got, exp, lat);
      nvec++;
      if (got !== exp || got !== 33'h0) begin
         nerr++;
         $display("FAIL sw_resp got=%h required %h", got, exp);
      end
      nvec++;
      if (lat != LATENCY) begin
         nerr++;
         $display("FAIL sw_latency got=%0d required %0d", lat, LATENCY);
      end
      issue(32'd1, 4'h0, 32'h0);
      collect(got, exp, lat);
      nvec++;
      if (got !== exp || got[DATA_W-1:0] !== 32'h0102_0304) begin
         nerr++;
         $display("FAIL lb_read got=%h required %h", got, exp);
      end
      nvec++;
      if (lat != LATENCY) begin
         nerr++;
         $display("FAIL lb_latency got=%0d required %0d", lat, LATENCY);
      end
   endtask

   task automatic test_strobe();
      logic [DATA_W:0] got, exp;
      int lat;
      issue(32'd0, 4'hF, 32'hFFFF_FFFF);
      issue(32'd0, 4'b0100, 32'h00AA_0000);
      issue(32'd0, 4'h0, 32'h0);
      collect(got, exp, lat);
      nvec++;
      if (got !== exp) begin
         nerr++; $display("FAIL strobe_fill_resp got=%h required %h", got, exp);
      end
      collect(got, exp, lat);
      nvec++;
      if (got !== exp || got !== 33'h0) begin
         nerr++; $display("FAIL strobe_write_resp got=%h required %h", got, exp);
      end
      collect(got, exp, lat);
      nvec++;
      if (got !== exp || got[DATA_W-1:0] !== 32'hFFAA_FFFF) begin
         nerr++; $display("FAIL strobe_read got=%h required %h", got, exp);
      end
   endtask

   task automatic test_backpressure();
      logic [ADDR_W-1:0] a [6];
      logic [DATA_W:0]   got, exp;
      int acc = 0;
      int got_n = 0;
      for (int i = 0; i < 6; i++) a[i] = ADDR_W'($urandom_range(0, WORDS - 1) * NB);
      resp_ready = 1'b0;
      req_wstrb  = '0;
      req_addr   = a[0];
      req_valid  = 1'b1;
      for (int cyc = 0; cyc < 80 && got_n < 6; cyc++) begin
         if (cyc == 7) begin
            nvec++;
            if (acc != RESP_DEPTH || req_ready !== 1'b0) begin
               nerr++;
               $display("FAIL bp_stall got accepts=%0d ready=%b required %0d/0", acc, req_ready, RESP_DEPTH);
            end
         end
         if (cyc == 8) resp_ready = 1'b1;
         if (resp_valid && resp_ready) begin
            got = {resp_err, resp_rdata};
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : {(DATA_W+1){1'bx}};
            nvec++;
            if (got !== exp) begin
               nerr++; $display("FAIL bp_order resp=%0d got=%h required %h", got_n, got, exp);
            end
            got_n++;
         end
         if (req_valid && req_ready) begin
            exp_q.push_back(model_access(a[acc], '0, '0));
            acc++;
         end
         @(negedge clk);
         if (acc < 6) req_addr = a[acc];
         else req_valid = 1'b0;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      nvec++;
      if (acc != 6 || got_n != 6) begin
         nerr++; $display("FAIL bp_complete got accepts=%0d resps=%0d required 6/6", acc, got_n);
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W:0] got, exp;
      int lat;
      issue(32'd8, 4'hF, 32'h0000_0055);
      issue(32'd8, 4'h0, 32'h0);
      collect(got, exp, lat);
      nvec++;
      if (got !== exp) begin
         nerr++; $display("FAIL b2b_write_resp got=%h required %h", got, exp);
      end
      collect(got, exp, lat);
      nvec++;
      if (got !== exp || got[DATA_W-1:0] !== 32'h55) begin
         nerr++; $display("FAIL b2b_read got=%h required %h", got, exp);
      end
   endtask

   task automatic test_bounds();
      logic [DATA_W:0]   got [3];
      logic [DATA_W:0]   exp [3];
      logic [DATA_W-1:0] prev0;
      int lat;
      prev0 = mdl[0];
      issue(ADDR_W'(WORDS * NB), 4'hF, 32'hDEAD_BEEF);
      issue(ADDR_W'(WORDS * NB), 4'h0, 32'h0);
      issue(32'd0, 4'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         collect(got[i], exp[i], lat);
         nvec++;
         if (got[i] !== exp[i]) begin
            nerr++; $display("FAIL bounds_resp%0d got=%h required %h", i, got[i], exp[i]);
         end
      end
`ifdef RAM_BOUNDS_CHECK_EN
      nvec++;
      if (got[0][DATA_W] !== 1'b1 || got[2][DATA_W-1:0] !== prev0) begin
         nerr++;
         $display("FAIL bounds_err got err=%b mem0=%h required 1/%h", got[0][DATA_W], got[2][DATA_W-1:0], prev0);
      end
`else
      nvec++;
      if (got[2] !== {1'b0, 32'hDEAD_BEEF} || got[0][DATA_W] !== 1'b0) begin
         nerr++;
         $display("FAIL bounds_alias got mem0=%h err=%b required deadbeef/0 (was %h)", got[2][DATA_W-1:0], got[0][DATA_W], prev0);
      end
`endif
   endtask

   task automatic test_mid_reset();
      logic [DATA_W:0]   got, exp;
      logic [DATA_W-1:0] v;
      int lat;
      int stale = 0;
      v = $urandom;
      issue(32'h30, 4'hF, v);
      collect(got, exp, lat);
      for (int i = 0; i < 3; i++) issue(ADDR_W'(i * NB), 4'h0, 32'h0);
      resetn = 1'b0;
      #1;
      nvec++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
         nerr++; $display("FAIL midreset_outputs got valid=%b ready=%b required 0/0", resp_valid, req_ready);
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      resp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp_valid) stale++;
      end
      resp_ready = 1'b0;
      nvec++;
      if (stale != 0) begin
         nerr++; $display("FAIL midreset_stale got %0d stale responses required 0", stale);
      end
      issue(32'h30, 4'h0, 32'h0);
      collect(got, exp, lat);
      nvec++;
      if (got !== exp || got[DATA_W-1:0] !== v) begin
         nerr++; $display("FAIL midreset_persist got=%h required %h", got, {1'b0, v});
      end
   endtask

   task automatic test_random(input int n);
      logic [DATA_W:0] got, exp, held;
      logic            held_v = 1'b0;
      logic            acc_now;
      int issued = 0;
      int done = 0;
      req_valid = 1'b0;
      for (int cyc = 0; cyc < 20000 && done < n; cyc++) begin
         resp_ready = ($urandom_range(0, 9) < 7);
         if (held_v) begin
            nvec++;
            if (resp_valid !== 1'b1 || {resp_err, resp_rdata} !== held) begin
               nerr++;
               $display("FAIL rand_hold got valid=%b data=%h required 1/%h", resp_valid, {resp_err, resp_rdata}, held);
            end
         end
         if (resp_valid && resp_ready) begin
            got = {resp_err, resp_rdata};
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : {(DATA_W+1){1'bx}};
            nvec++;
            if (got !== exp) begin
               nerr++; $display("FAIL rand_resp n=%0d got=%h required %h", done, got, exp);
            end
            done++;
            held_v = 1'b0;
         end else begin
            held_v = resp_valid;
            held   = {resp_err, resp_rdata};
         end
         acc_now = req_valid && req_ready;
         if (acc_now) begin
            exp_q.push_back(model_access(req_addr, req_wstrb, req_wdata));
            issued++;
         end
         @(negedge clk);
         if (!req_valid || acc_now) begin
            if (issued < n && $urandom_range(0, 3) != 0) begin
               req_valid = 1'b1;
               req_addr  = ADDR_W'($urandom_range(0, WORDS + 15) * NB + $urandom_range(0, NB - 1));
               req_wstrb = ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom);
               req_wdata = $urandom;
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      nvec++;
      if (done != n || exp_q.size() != 0) begin
         nerr++; $display("FAIL rand_complete got %0d resps, %0d pending required %0d/0", done, exp_q.size(), n);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_basic();
      test_strobe();
      test_backpressure();
      test_back_to_back();
      test_bounds();
      test_mid_reset();
      test_random(300);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
